// File: rtl/lightcube8_pkg.sv
// Shared types and constants for the lightcube8 UART frame path.
// Holds the frame geometry, the sync header bytes and the assembler state/error encodings.
package lightcube8_pkg;

    localparam int         NBYTES = 64;
    localparam int         IDX_W  = $clog2(NBYTES);
    localparam logic [7:0] HDR0   = 8'hA5;
    localparam logic [7:0] HDR1   = 8'h5A;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CSUM
    } asm_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: reloads on load, counts down while run, flags expiry at zero.
// The counter parks at zero whenever it is not running.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam int            CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= RELOAD;
        end else if (!run) begin
            count_q <= '0;
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign expired = run && (count_q == '0);

endmodule

// File: rtl/uart_frame_assembler.sv
// Hunts for the A5 5A header, gathers a 64-byte cube frame plus 8-bit checksum,
// and commits good frames to frame_cube; drops on bad checksum or inter-byte timeout.
module uart_frame_assembler
    import lightcube8_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  frame_cube [NBYTES-1:0],
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    asm_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       sum_q;
    logic [7:0]       staging [NBYTES-1:0];
    err_code_t        err_q;

    logic start, take_data, commit, drop_csum, drop_timeout;
    logic tmr_load, tmr_run, tmr_expired;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .run    (tmr_run),
        .expired(tmr_expired)
    );

    assign tmr_run = en && ((state_q == DATA) || (state_q == CSUM));

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        take_data    = 1'b0;
        commit       = 1'b0;
        drop_csum    = 1'b0;
        drop_timeout = 1'b0;
        tmr_load     = 1'b0;

        if (!en) begin
            state_d = IDLE;
        end else if (rx_valid) begin
            // A byte arriving in the expiry cycle is taken; the watchdog is simply reloaded.
            case (state_q)
                IDLE: if (rx_data == HDR0) state_d = HDR;
                HDR: begin
                    if (rx_data == HDR1) begin
                        state_d  = DATA;
                        start    = 1'b1;
                        tmr_load = 1'b1;
                    end else if (rx_data != HDR0) begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    take_data = 1'b1;
                    tmr_load  = 1'b1;
                    if (idx_q == LAST_IDX) state_d = CSUM;
                end
                CSUM: begin
                    state_d = IDLE;
                    if (rx_data == sum_q) commit = 1'b1;
                    else drop_csum = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (tmr_expired) begin
            state_d      = IDLE;
            drop_timeout = 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: staging and frame_cube are cleared on reset because the frame is observable after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q       <= '0;
            sum_q       <= '0;
            staging     <= '{default: '0};
            frame_cube  <= '{default: '0};
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_q       <= ERR_NONE;
            frame_count <= '0;
        end else begin
            frame_done <= commit;
            frame_err  <= drop_csum | drop_timeout;

            if (!en) begin
                idx_q <= '0;
            end else if (start) begin
                idx_q <= '0;
                sum_q <= '0;
            end else if (take_data) begin
                staging[idx_q] <= rx_data;
                sum_q          <= sum_q + rx_data;
                if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
            end

            // The whole staged frame lands at once, so frame_cube is never partially updated.
            if (commit) begin
                frame_cube  <= staging;
                frame_count <= frame_count + 16'd1;
            end

            if (drop_csum)         err_q <= ERR_CSUM;
            else if (drop_timeout) err_q <= ERR_TIMEOUT;
        end
    end

    assign err_code = err_q;

endmodule
